// File: rtl/stream_arb_pkg.sv
// Shared arbiter types and helpers: FSM state codes, port-index sizing and the
// round-robin pick used by rr_select.
package stream_arb_pkg;

  localparam int unsigned MAX_PORTS = 16;
  localparam int unsigned MAX_IDX_W = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  // Port index width for a given port count (at least one bit).
  function automatic int unsigned port_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First requester at or after last+1 (mod n); equivalent to rotate,
  // priority-encode, rotate back.
  function automatic rr_pick_t rr_pick(input logic [MAX_PORTS-1:0] req,
                                       input logic [MAX_IDX_W-1:0] last,
                                       input int unsigned          n);
    rr_pick_t    r;
    int unsigned idx;
    r = '0;
    for (int unsigned i = 0; i < MAX_PORTS; i++) begin
      idx = (32'(last) + 32'd1 + i) % n;
      if ((i < n) && !r.valid && req[MAX_IDX_W'(idx)]) begin
        r.valid = 1'b1;
        r.idx   = MAX_IDX_W'(idx);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin selector: first requester after last, wrapping.
module rr_select
  import stream_arb_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = port_idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] grant_c,
  output logic             valid_c
);

  rr_pick_t pick;

  always_comb begin
    pick    = rr_pick(MAX_PORTS'(req), MAX_IDX_W'(last), N);
    grant_c = IDX_W'(pick.idx);
    valid_c = pick.valid;
  end

endmodule

// File: rtl/stream_packet_arbiter.sv
// Packet-granular round-robin AXI-Stream arbiter with a registered output stage
// and grant-time downstream space check. Optional per-port packet counters
// under STREAM_ARB_PKT_COUNT_EN.
module stream_packet_arbiter
  import stream_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = 4,
  parameter int unsigned WIDTH_IN_BYTES = 4,
  parameter int unsigned TID_WIDTH      = 8,
  parameter int unsigned DEPTH_EXP      = 16,
  parameter int unsigned MAX_PKT_WORDS  = 256
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NUM_PORTS-1:0]                  in_tvalid,
  output logic [NUM_PORTS-1:0]                  in_tready,
  input  logic [NUM_PORTS*8*WIDTH_IN_BYTES-1:0] in_tdata,
  input  logic [NUM_PORTS*WIDTH_IN_BYTES-1:0]   in_tkeep,
  input  logic [NUM_PORTS-1:0]                  in_tlast,
  input  logic [DEPTH_EXP:0]                    free_words,
  output logic                                  out_tvalid,
  input  logic                                  out_tready,
  output logic [8*WIDTH_IN_BYTES-1:0]           out_tdata,
  output logic [WIDTH_IN_BYTES-1:0]             out_tkeep,
  output logic                                  out_tlast,
  output logic [TID_WIDTH-1:0]                  out_tid,
  output logic                                  busy
`ifdef STREAM_ARB_PKT_COUNT_EN
  ,
  output logic [NUM_PORTS*16-1:0]               pkt_count
`endif
);

  localparam int unsigned DATA_W = 8 * WIDTH_IN_BYTES;
  localparam int unsigned IDX_W  = port_idx_w(NUM_PORTS);
  localparam int unsigned CNT_W  = 16;

  logic [0:0]          state, state_next;
  logic [IDX_W-1:0]    grant, grant_next;
  logic [IDX_W-1:0]    last_grant, last_grant_next;
  logic [IDX_W-1:0]    winner_c;
  logic                winner_valid_c;
  logic                space_ok_c;
  logic                load_ok_c;
  logic                xfer_c;
  logic [DATA_W-1:0]   sel_data_c;
  logic [WIDTH_IN_BYTES-1:0] sel_keep_c;
  logic                sel_last_c;
  logic                sel_valid_c;

  rr_select #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .req     (in_tvalid),
    .last    (last_grant),
    .grant_c (winner_c),
    .valid_c (winner_valid_c)
  );

  // Room for a whole packet plus the beat parked in the output register.
  assign space_ok_c = (MAX_PKT_WORDS == 0) || (32'(free_words) >= (MAX_PKT_WORDS + 32'd1));
  assign load_ok_c  = !out_tvalid || out_tready;

  // Granted-port beat mux.
  always_comb begin
    sel_data_c  = '0;
    sel_keep_c  = '0;
    sel_last_c  = 1'b0;
    sel_valid_c = 1'b0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      if (grant == IDX_W'(p)) begin
        sel_data_c  = in_tdata[p*DATA_W +: DATA_W];
        sel_keep_c  = in_tkeep[p*WIDTH_IN_BYTES +: WIDTH_IN_BYTES];
        sel_last_c  = in_tlast[p];
        sel_valid_c = in_tvalid[p];
      end
    end
  end

  // Next-state and handshake logic.
  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_grant_next = last_grant;
    in_tready       = '0;
    xfer_c          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (winner_valid_c && space_ok_c) begin
          grant_next = winner_c;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        in_tready[grant] = load_ok_c;
        xfer_c           = sel_valid_c && load_ok_c;
        if (xfer_c && sel_last_c) begin
          last_grant_next = grant;
          state_next      = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= IDX_W'(NUM_PORTS - 1);
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_grant <= last_grant_next;
      busy       <= (state_next == ST_BUSY);
    end
  end

  // Single-entry output register; holds while downstream stalls.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_tkeep  <= '0;
      out_tlast  <= 1'b0;
      out_tid    <= '0;
    end else if (load_ok_c) begin
      out_tvalid <= xfer_c;
      if (xfer_c) begin
        out_tdata <= sel_data_c;
        out_tkeep <= sel_keep_c;
        out_tlast <= sel_last_c;
        out_tid   <= TID_WIDTH'(grant);
      end
    end
  end

`ifdef STREAM_ARB_PKT_COUNT_EN
  // Per-port completed-packet counters, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pkt_count <= '0;
    end else begin
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
        if (xfer_c && sel_last_c && (grant == IDX_W'(p))) begin
          pkt_count[p*CNT_W +: CNT_W] <= pkt_count[p*CNT_W +: CNT_W] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Directed scoreboard bench for stream_packet_arbiter (4 ports, 32-bit data).
module tb_stream_packet_arbiter;

  localparam int unsigned NP = 4;
  localparam int unsigned WB = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 8;
  localparam int unsigned DE = 16;

  logic             clk;
  logic             reset_n;
  logic [NP-1:0]    in_tvalid;
  logic [NP-1:0]    in_tready;
  logic [NP*DW-1:0] in_tdata;
  logic [NP*WB-1:0] in_tkeep;
  logic [NP-1:0]    in_tlast;
  logic [DE:0]      free_words;
  logic             out_tvalid;
  logic             out_tready;
  logic [DW-1:0]    out_tdata;
  logic [WB-1:0]    out_tkeep;
  logic             out_tlast;
  logic [TW-1:0]    out_tid;
  logic             busy;
`ifdef STREAM_ARB_PKT_COUNT_EN
  logic [NP*16-1:0] pkt_count;
`endif

  stream_packet_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .in_tdata   (in_tdata),
    .in_tkeep   (in_tkeep),
    .in_tlast   (in_tlast),
    .free_words (free_words),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tdata  (out_tdata),
    .out_tkeep  (out_tkeep),
    .out_tlast  (out_tlast),
    .out_tid    (out_tid),
    .busy       (busy)
`ifdef STREAM_ARB_PKT_COUNT_EN
    ,
    .pkt_count  (pkt_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [63:0]   exp_q[$];
  logic [DW-1:0] src_data[NP][64];
  logic [WB-1:0] src_keep[NP][64];
  logic          src_last[NP][64];
  int            src_wr[NP];
  int            src_rd[NP];
  logic [NP-1:0] hold;
  logic [NP-1:0] fire;
  int            tid_cnt[NP];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Per-port sources present the head of their beat queue.
  always_comb begin
    in_tvalid = '0;
    in_tdata  = '0;
    in_tkeep  = '0;
    in_tlast  = '0;
    for (int p = 0; p < int'(NP); p++) begin
      in_tvalid[p]          = (src_rd[p] < src_wr[p]) && !hold[p];
      in_tdata[p*DW +: DW]  = src_data[p][6'(src_rd[p])];
      in_tkeep[p*WB +: WB]  = src_keep[p][6'(src_rd[p])];
      in_tlast[p]           = src_last[p][6'(src_rd[p])];
    end
  end

  // Output monitor and input handshake capture, away from the active edge.
  always @(negedge clk) begin
    logic [63:0] obs;
    logic [63:0] e;
    if (reset_n) begin
      for (int p = 0; p < int'(NP); p++) fire[p] = in_tvalid[p] && in_tready[p];
      if (out_tvalid && out_tready) begin
        obs = {19'd0, out_tid, out_tlast, out_tkeep, out_tdata};
        if (exp_q.size() == 0) begin
          chk("beat_extra", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("beat", obs, e);
          if (out_tid < TW'(NP)) tid_cnt[2'(out_tid)]++;
        end
      end
    end else begin
      fire = '0;
    end
  end

  always begin
    @(posedge clk);
    #1;
    for (int p = 0; p < int'(NP); p++) if (fire[p]) src_rd[p]++;
  end

  task automatic enq(input int p, input int n, input int id);
    logic [DW-1:0] d;
    logic [WB-1:0] k;
    logic          l;
    for (int b = 0; b < n; b++) begin
      l = (b == n - 1);
      k = l ? 4'h7 : 4'hF;
      d = {8'(p), 8'(id), 8'(b), 8'h5A};
      src_data[2'(p)][6'(src_wr[2'(p)])] = d;
      src_keep[2'(p)][6'(src_wr[2'(p)])] = k;
      src_last[2'(p)][6'(src_wr[2'(p)])] = l;
      src_wr[2'(p)]++;
      exp_q.push_back({19'd0, 8'(p), l, k, d});
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(negedge clk);
    for (int p = 0; p < int'(NP); p++) begin
      src_rd[p]  = 0;
      src_wr[p]  = 0;
      tid_cnt[p] = 0;
    end
    hold = '0;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wait_vld(input string tag);
    int n;
    n = 0;
    while (!out_tvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid_timeout"}, 64'(out_tvalid), 64'd1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] hist;
    reset_n    = 1'b0;
    out_tready = 1'b1;
    free_words = 17'd1000;
    hold       = '0;
    fire       = '0;
    for (int p = 0; p < int'(NP); p++) begin
      src_rd[p]  = 0;
      src_wr[p]  = 0;
      tid_cnt[p] = 0;
    end
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_out_tvalid", 64'(out_tvalid), 64'd0);
    chk("rst_in_tready", 64'(in_tready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_tid", 64'(out_tid), 64'd0);
    chk("rst_out_tdata", 64'(out_tdata), 64'd0);
    chk("rst_out_tlast", 64'(out_tlast), 64'd0);
`ifdef STREAM_ARB_PKT_COUNT_EN
    chk("rst_pkt_count", 64'(pkt_count), 64'd0);
`endif

    // Ports 0 and 2, 3-beat packets: port 0 first, one IDLE bubble between
    @(posedge clk);
    #1;
    enq(0, 3, 1);
    enq(2, 3, 2);
    hist = '0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      hist = {hist[7:0], busy};
    end
    chk("t1_busy_seq", 64'(hist), 64'(9'b011101110));
    drain("t1");

    // All ports always requesting, 1-beat packets: strict 0,1,2,3 rotation
    do_reset();
    @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++)
      for (int p = 0; p < int'(NP); p++) enq(p, 1, 16 + k);
    drain("t2");
    for (int p = 0; p < int'(NP); p++) chk($sformatf("t2_share_p%0d", p), 64'(tid_cnt[p]), 64'd10);
`ifdef STREAM_ARB_PKT_COUNT_EN
    for (int p = 0; p < int'(NP); p++)
      chk($sformatf("t2_pkt_count_p%0d", p), 64'(pkt_count[p*16 +: 16]), 64'd10);
`endif

    // Space check boundary: 256 free blocks, 257 grants
    do_reset();
    @(posedge clk);
    #1;
    free_words = 17'd256;
    enq(1, 2, 3);
    repeat (4) @(negedge clk);
    chk("t3_noroom_in_tready", 64'(in_tready), 64'd0);
    chk("t3_noroom_busy", 64'(busy), 64'd0);
    chk("t3_noroom_out_tvalid", 64'(out_tvalid), 64'd0);
    @(posedge clk);
    #1;
    free_words = 17'd257;
    @(negedge clk);
    chk("t3_busy_same_cycle", 64'(busy), 64'd0);
    @(negedge clk);
    chk("t3_busy_granted", 64'(busy), 64'd1);
    chk("t3_out_tvalid_early", 64'(out_tvalid), 64'd0);
    @(negedge clk);
    chk("t3_out_tvalid", 64'(out_tvalid), 64'd1);
    chk("t3_out_tid", 64'(out_tid), 64'd1);
    drain("t3");
    free_words = 17'd1000;

    // Downstream stall for 5 cycles mid-packet
    do_reset();
    @(posedge clk);
    #1;
    enq(0, 4, 4);
    wait_vld("t4");
    @(posedge clk);
    #1;
    out_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_data", 64'(out_tdata), 64'({8'd0, 8'd4, 8'd1, 8'h5A}));
      chk("t4_hold_valid", 64'(out_tvalid), 64'd1);
      chk("t4_hold_in_tready", 64'(in_tready), 64'd0);
    end
    @(posedge clk);
    #1;
    out_tready = 1'b1;
    drain("t4");

    // Granted source pauses 3 cycles while port 3 waits
    do_reset();
    @(posedge clk);
    #1;
    enq(0, 4, 5);
    wait_vld("t5");
    @(posedge clk);
    #1;
    hold[0] = 1'b1;
    enq(3, 2, 6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_busy_held", 64'(busy), 64'd1);
      chk("t5_p3_not_ready", 64'(in_tready[3]), 64'd0);
    end
    @(posedge clk);
    #1;
    hold[0] = 1'b0;
    drain("t5");

    // Mid-packet reset abandons the packet and restores port 0 priority
    do_reset();
    @(posedge clk);
    #1;
    enq(0, 1, 10);
    drain("t6_pre");
    @(posedge clk);
    #1;
    enq(2, 4, 7);
    wait_vld("t6");
    do_reset();
    @(negedge clk);
    chk("t6_rst_out_tvalid", 64'(out_tvalid), 64'd0);
    chk("t6_rst_in_tready", 64'(in_tready), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
`ifdef STREAM_ARB_PKT_COUNT_EN
    chk("t6_rst_pkt_count", 64'(pkt_count), 64'd0);
`endif
    @(posedge clk);
    #1;
    enq(0, 2, 8);
    enq(1, 2, 9);
    drain("t6");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
